// File: rtl/addsub_share_arb_pkg.sv
// rtl/addsub_share_arb_pkg.sv - shared constants and helpers for the shared add/sub arbiter
package addsub_share_arb_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_R = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Width of a requester index; never below one bit so ports stay legal.
    function automatic int id_width(input int r);
        return (r <= 2) ? 1 : $clog2(r);
    endfunction

endpackage

// File: rtl/Add_Sub_Nbit.sv
// rtl/Add_Sub_Nbit.sv - N-bit two's-complement add/subtract cell
//
// Ports:
//   a, b : N-bit operands
//   k    : 0 -> a + b, 1 -> a - b (b inverted, carry-in = k)
//   s    : N-bit wrapped result
module Add_Sub_Nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         k,
    output logic [N-1:0] s
);

    assign s = a + (b ^ {N{k}}) + N'(k);

endmodule

// File: rtl/addsub_share_arb_rr_arbiter.sv
// rtl/addsub_share_arb_rr_arbiter.sv - combinational round-robin grant selector
//
// Ports:
//   req     : per-requester request bits
//   ptr     : highest-priority index for this cycle
//   en      : grant enable; no grant when low
//   gnt     : one-hot grant
//   gnt_idx : index of the granted requester (0 when no grant)
module rr_arbiter
    import addsub_share_arb_pkg::*;
#(
    parameter int R   = DEFAULT_R,
    parameter int IDW = id_width(R)
) (
    input  logic [R-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [R-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);

    logic           found;
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int j = 0; j < R; j++) begin
            // ptr < R and j < R, so one conditional subtract gives (ptr + j) mod R
            sum = {1'b0, ptr} + (IDW+1)'(j);
            if (sum >= (IDW+1)'(R)) begin
                sum = sum - (IDW+1)'(R);
            end
            idx = sum[IDW-1:0];
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/addsub_share_arb.sv
// rtl/addsub_share_arb.sv - round-robin sharing of one add/sub cell among R requesters
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b        : packed operands, requester i at [i*N +: N]
//   req_sub             : per-requester op select (OP_ADD / OP_SUB)
//   res_valid/res_ready : result handshake
//   res_data, res_id    : wrapped result and issuing requester
//   res_ovf             : signed overflow of the result
//   grant_cnt           : wrapping count of accepted operations
module addsub_share_arb
    import addsub_share_arb_pkg::*;
#(
    parameter int N   = DEFAULT_N,
    parameter int R   = DEFAULT_R,
    parameter int IDW = id_width(R)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R*N-1:0] req_a,
    input  logic [R*N-1:0] req_b,
    input  logic [R-1:0]   req_sub,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N-1:0]   res_data,
    output logic [IDW-1:0] res_id,
    output logic           res_ovf,
    output logic [15:0]    grant_cnt
);

    logic [IDW-1:0] ptr;
    logic [R-1:0]   gnt;
    logic [IDW-1:0] gnt_idx;
    logic           can_accept;
    logic           xfer;
    logic [N-1:0]   a_sel;
    logic [N-1:0]   b_sel;
    logic           sub_sel;
    logic [N-1:0]   b_eff;
    logic [N-1:0]   sum;
    logic           ovf;
    logic [IDW-1:0] ptr_next;

    // Single output stage: accept only when the register is empty or draining.
    assign can_accept = !res_valid || res_ready;

    rr_arbiter #(
        .R   (R),
        .IDW (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (can_accept && rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        sub_sel = OP_ADD;
        for (int i = 0; i < R; i++) begin
            if (gnt_idx == IDW'(i)) begin
                a_sel   = req_a[i*N +: N];
                b_sel   = req_b[i*N +: N];
                sub_sel = req_sub[i];
            end
        end
    end

    Add_Sub_Nbit #(
        .N (N)
    ) u_addsub (
        .a (a_sel),
        .b (b_sel),
        .k (sub_sel),
        .s (sum)
    );

    // Overflow: effective operands share a sign but the result does not.
    assign b_eff = (sub_sel == OP_SUB) ? ~b_sel : b_sel;
    assign ovf   = (a_sel[N-1] == b_eff[N-1]) && (sum[N-1] != a_sel[N-1]);

    assign ptr_next = (gnt_idx == IDW'(R-1)) ? '0 : gnt_idx + IDW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_ovf   <= 1'b0;
            grant_cnt <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            res_valid <= 1'b1;
            res_data  <= sum;
            res_id    <= gnt_idx;
            res_ovf   <= ovf;
            grant_cnt <= grant_cnt + 16'd1;
            ptr       <= ptr_next;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addsub_share_arb.sv
// tb/tb_addsub_share_arb.sv - self-checking bench for addsub_share_arb
module tb_addsub_share_arb;

    localparam int N   = 4;
    localparam int R   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic [R-1:0]   req_sub;
    logic           res_valid;
    logic           res_ready;
    logic [N-1:0]   res_data;
    logic [IDW-1:0] res_id;
    logic           res_ovf;
    logic [15:0]    grant_cnt;

    int op_a [R];
    int op_b [R];

    int total = 0;
    int bad   = 0;

    // reference state
    int m_ptr, m_valid, m_data, m_id, m_ovf, m_cnt, m_gnt;

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < R; i++) begin
            req_a[i*N +: N] = N'(op_a[i]);
            req_b[i*N +: N] = N'(op_b[i]);
        end
    end

    addsub_share_arb #(.N(N), .R(R), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf),
        .grant_cnt (grant_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= (1 << (N-1))) ? v - (1 << N) : v;
    endfunction

    // One clock: check the combinational grant, advance the model, check registers.
    task automatic cycle();
        int exp_ready;
        int sa, sb, r;
        #2;
        m_gnt = -1;
        if (rst_n && (!m_valid || res_ready)) begin
            for (int j = 0; j < R; j++) begin
                if (m_gnt < 0 && req_valid[(m_ptr + j) % R]) m_gnt = (m_ptr + j) % R;
            end
        end
        exp_ready = (m_gnt >= 0) ? (1 << m_gnt) : 0;
        chk("req_ready", int'(req_ready), exp_ready);
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_id = 0; m_ovf = 0; m_cnt = 0; m_ptr = 0;
        end else if (m_gnt >= 0) begin
            sa = to_signed(op_a[m_gnt] & ((1 << N) - 1));
            sb = to_signed(op_b[m_gnt] & ((1 << N) - 1));
            r  = req_sub[m_gnt] ? sa - sb : sa + sb;
            m_valid = 1;
            m_data  = r & ((1 << N) - 1);
            m_ovf   = (r < -(1 << (N-1)) || r > (1 << (N-1)) - 1) ? 1 : 0;
            m_id    = m_gnt;
            m_ptr   = (m_gnt + 1) % R;
            m_cnt   = (m_cnt + 1) & 16'hffff;
        end else if (res_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("res_valid", int'(res_valid), m_valid);
        chk("grant_cnt", int'(grant_cnt), m_cnt);
        if (m_valid != 0) begin
            chk("res_data", int'(res_data), m_data);
            chk("res_id", int'(res_id), m_id);
            chk("res_ovf", int'(res_ovf), m_ovf);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b, input logic sub);
        op_a[i]    = a;
        op_b[i]    = b;
        req_sub[i] = sub;
    endtask

    typedef struct {
        int   a;
        int   b;
        logic sub;
        int   exp_data;
        int   exp_ovf;
    } vec_t;

    vec_t vecs [8];

    initial begin
        m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0; m_ovf = 0; m_cnt = 0; m_gnt = -1;
        vecs[0] = '{7, 1, 1'b0, 8, 1};
        vecs[1] = '{8, 1, 1'b1, 7, 1};
        vecs[2] = '{8, 8, 1'b1, 0, 0};
        vecs[3] = '{3, 5, 1'b1, 14, 0};
        vecs[4] = '{2, 3, 1'b0, 5, 0};
        vecs[5] = '{15, 15, 1'b0, 14, 0};
        vecs[6] = '{4, 4, 1'b0, 8, 1};
        vecs[7] = '{0, 1, 1'b1, 15, 0};

        rst_n     = 1'b0;
        req_valid = '1;
        req_sub   = '0;
        res_ready = 1'b1;
        for (int i = 0; i < R; i++) set_op(i, i, 1, 1'b0);
        @(posedge clk);
        #1;

        // reset with every requester asking
        cycle();
        cycle();
        chk("reset_res_valid", int'(res_valid), 0);
        chk("reset_grant_cnt", int'(grant_cnt), 0);

        // continuous round robin
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_id", int'(res_id), k % R);
            chk("rr_data", int'(res_data), (k % R) + 1);
        end
        chk("rr_grant_cnt", int'(grant_cnt), 5);

        // backpressure with held result 3-5
        req_valid = 4'b0100;
        set_op(2, 3, 5, 1'b1);
        cycle();
        chk("bp_held_data", int'(res_data), 14);
        res_ready = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_stable_data", int'(res_data), 14);
            chk("bp_stable_id", int'(res_id), 2);
        end
        res_ready = 1'b1;
        cycle();
        chk("bp_refill_valid", int'(res_valid), 1);
        chk("bp_refill_id", int'(res_id), 3);

        // table of arithmetic corner vectors on requester 0
        req_valid = 4'b0001;
        for (int v = 0; v < 8; v++) begin
            set_op(0, vecs[v].a, vecs[v].b, vecs[v].sub);
            cycle();
            chk("vec_data", int'(res_data), vecs[v].exp_data);
            chk("vec_ovf", int'(res_ovf), vecs[v].exp_ovf);
        end

        // sparse requests starting from ptr=2
        req_valid = 4'b0010;
        set_op(1, 1, 1, 1'b0);
        cycle();
        req_valid = 4'b1010;
        set_op(3, 2, 2, 1'b0);
        cycle();
        chk("sparse_first", int'(res_id), 3);
        req_valid = 4'b0010;
        cycle();
        chk("sparse_second", int'(res_id), 1);
        req_valid = 4'b0000;
        cycle();
        chk("idle_drop", int'(res_valid), 0);
        req_valid = 4'b0101;
        cycle();
        chk("ptr_held", int'(res_id), 2);

        // reset while a result is stalled
        req_valid = 4'b0000;
        res_ready = 1'b0;
        cycle();
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        cycle();
        chk("midrst_valid", int'(res_valid), 0);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        cycle();
        chk("midrst_first_id", int'(res_id), 0);

        // randomized traffic under the requester protocol
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < R; i++) begin
                if (!req_valid[i] || m_gnt == i || !rst_n) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_op(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                           logic'($urandom_range(0, 1)));
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
